// File: rtl/pwm_duty_sched.sv
// rtl/pwm_duty_sched.sv - per-motor duty scheduler with slew limit and overcurrent fault latch
module pwm_duty_sched #(
    parameter logic [10:0] SLEW      = 11'd16,
    parameter logic [2:0]  OVR_LIMIT = 3'd4,
    parameter logic [10:0] DUTY_MIN  = 11'd64,
    parameter logic [10:0] DUTY_MAX  = 11'd1983
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [10:0] spd_req,
    input  logic        PWM_synch,
    input  logic        ovr_I_blank,
    input  logic        OVR_I,
    input  logic        fault_clr,
    output logic [10:0] duty,
    output logic        running,
    output logic        fault
);

    localparam logic [10:0] MID = 11'h400;

    typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

    state_t      state_q, state_d;
    logic [10:0] duty_q, duty_d;
    logic        running_q, running_d;
    logic        fault_q, fault_d;
    logic        ovr_seen_q, ovr_seen_d;
    logic [2:0]  ovr_cnt_q, ovr_cnt_d;

    logic        hit;
    logic        per;
    logic [2:0]  cnt_upd;
    logic [10:0] tgt_raw, tgt_clamp, tgt;
    logic [11:0] gap, up_sum, dn_diff;
    logic [10:0] duty_upd;

    assign hit     = OVR_I & ~ovr_I_blank;
    assign per     = ovr_seen_q | hit;
    assign tgt_raw = {~spd_req[10], spd_req[9:0]};
    assign tgt     = (en && state_q == RUN) ? tgt_clamp : MID;

    always_comb begin
        tgt_clamp = tgt_raw;
        if (tgt_raw < DUTY_MIN) begin
            tgt_clamp = DUTY_MIN;
        end else if (tgt_raw > DUTY_MAX) begin
            tgt_clamp = DUTY_MAX;
        end
    end

    always_comb begin
        if (!per) begin
            cnt_upd = 3'd0;
        end else if (ovr_cnt_q == 3'd7) begin
            cnt_upd = 3'd7;
        end else begin
            cnt_upd = ovr_cnt_q + 3'd1;
        end
    end

    // Step toward tgt by at most SLEW; 12-bit sums saturate rather than wrap.
    always_comb begin
        up_sum   = {1'b0, duty_q} + {1'b0, SLEW};
        dn_diff  = {1'b0, duty_q} - {1'b0, SLEW};
        gap      = 12'd0;
        duty_upd = duty_q;
        if (tgt >= duty_q) begin
            gap = {1'b0, tgt} - {1'b0, duty_q};
            if (gap <= {1'b0, SLEW}) begin
                duty_upd = tgt;
            end else begin
                duty_upd = up_sum[11] ? 11'h7FF : up_sum[10:0];
            end
        end else begin
            gap = {1'b0, duty_q} - {1'b0, tgt};
            if (gap <= {1'b0, SLEW}) begin
                duty_upd = tgt;
            end else begin
                duty_upd = dn_diff[11] ? 11'h000 : dn_diff[10:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        duty_d     = duty_q;
        ovr_cnt_d  = ovr_cnt_q;
        ovr_seen_d = ovr_seen_q | hit;
        case (state_q)
            IDLE: begin
                duty_d = MID;
                if (PWM_synch) begin
                    ovr_cnt_d  = cnt_upd;
                    ovr_seen_d = 1'b0;
                    if (en && !fault_q) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (PWM_synch) begin
                    ovr_cnt_d  = cnt_upd;
                    ovr_seen_d = 1'b0;
                    if (cnt_upd >= OVR_LIMIT) begin
                        state_d = FAULT;
                        duty_d  = MID;
                    end else begin
                        duty_d = duty_upd;
                        if (!en && duty_upd == MID) begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            FAULT: begin
                duty_d     = MID;
                ovr_seen_d = ovr_seen_q;
                if (fault_clr) begin
                    state_d    = IDLE;
                    ovr_cnt_d  = 3'd0;
                    ovr_seen_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                duty_d  = MID;
            end
        endcase
        running_d = (state_d == RUN);
        fault_d   = (state_d == FAULT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            duty_q     <= MID;
            running_q  <= 1'b0;
            fault_q    <= 1'b0;
            ovr_seen_q <= 1'b0;
            ovr_cnt_q  <= 3'd0;
        end else begin
            state_q    <= state_d;
            duty_q     <= duty_d;
            running_q  <= running_d;
            fault_q    <= fault_d;
            ovr_seen_q <= ovr_seen_d;
            ovr_cnt_q  <= ovr_cnt_d;
        end
    end

    assign duty    = duty_q;
    assign running = running_q;
    assign fault   = fault_q;

endmodule

// File: tb/tb_pwm_duty_sched.sv
// tb/tb_pwm_duty_sched.sv - scoreboard bench for pwm_duty_sched
module tb_pwm_duty_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [10:0] spd_req = 11'd0;
    logic        PWM_synch = 1'b0;
    logic        ovr_I_blank = 1'b0;
    logic        OVR_I = 1'b0;
    logic        fault_clr = 1'b0;
    logic [10:0] duty;
    logic        running;
    logic        fault;

    int n_checks = 0;
    int n_fail = 0;

    logic [12:0] exp_q[$];
    logic [12:0] exp_cur = {2'b00, 11'h400};
    logic        evt = 1'b0;

    pwm_duty_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .spd_req     (spd_req),
        .PWM_synch   (PWM_synch),
        .ovr_I_blank (ovr_I_blank),
        .OVR_I       (OVR_I),
        .fault_clr   (fault_clr),
        .duty        (duty),
        .running     (running),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) evt <= PWM_synch | fault_clr;

    task automatic check(input string name, input logic [12:0] want);
        n_checks++;
        if ({fault, running, duty} !== want) begin
            n_fail++;
            $display("FAIL %s t=%0t got fault=%0b running=%0b duty=%03h want fault=%0b running=%0b duty=%03h",
                     name, $time, fault, running, duty, want[12], want[11], want[10:0]);
        end
    endtask

    // Monitor: pops after every synch/clear edge, otherwise outputs must hold.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_cur = {2'b00, 11'h400};
        end else if (evt) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event t=%0t duty=%03h", $time, duty);
            end else begin
                exp_cur = exp_q.pop_front();
                check("update", exp_cur);
            end
        end else begin
            check("hold", exp_cur);
        end
    end

    // ovr_mode: 0 none, 1 hit inside blanking, 2 unblanked hit, 3 spd_req glitch
    task automatic do_period(input logic [10:0] ed, input logic er, input logic ef, input int ovr_mode);
        logic [10:0] saved;
        @(posedge clk); #1;
        PWM_synch = 1'b1;
        exp_q.push_back({ef, er, ed});
        @(posedge clk); #1;
        PWM_synch = 1'b0;
        @(posedge clk); #1;
        ovr_I_blank = (ovr_mode == 1);
        saved = spd_req;
        if (ovr_mode == 3) spd_req = 11'h400;
        @(posedge clk); #1;
        OVR_I = (ovr_mode == 1 || ovr_mode == 2);
        @(posedge clk); #1;
        OVR_I = 1'b0;
        spd_req = saved;
        @(posedge clk); #1;
        ovr_I_blank = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {2'b00, 11'h400});
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Ramp up to +200: entry period holds 0x400, then 12 steps of 16 and one of 8.
        en = 1'b1;
        spd_req = 11'd200;
        do_period(11'h400, 1'b1, 1'b0, 0);
        for (int k = 1; k <= 12; k++) do_period(11'(11'h400 + 16 * k), 1'b1, 1'b0, 0);
        do_period(11'h4C8, 1'b1, 1'b0, 0);
        do_period(11'h4C8, 1'b1, 1'b0, 3);
        do_period(11'h4C8, 1'b1, 1'b0, 0);

        // Full negative request clamps at DUTY_MIN.
        spd_req = 11'h400;
        d = 'h4C8;
        while (d != 64) begin
            d = (d - 64 <= 16) ? 64 : d - 16;
            do_period(11'(d), 1'b1, 1'b0, 0);
        end
        do_period(11'd64, 1'b1, 1'b0, 0);

        // Climb to 0x480, then drop en and ramp back to IDLE.
        spd_req = 11'd128;
        while (d != 'h480) begin
            d = ('h480 - d <= 16) ? 'h480 : d + 16;
            do_period(11'(d), 1'b1, 1'b0, 0);
        end
        en = 1'b0;
        for (int k = 1; k <= 8; k++) do_period(11'(11'h480 - 16 * k), (k != 8), 1'b0, 0);
        do_period(11'h400, 1'b0, 1'b0, 0);

        // Blanked overcurrent never counts.
        en = 1'b1;
        spd_req = 11'd0;
        for (int k = 0; k < 10; k++) do_period(11'h400, 1'b1, 1'b0, 1);

        // Three hits then a clean period reset the count; four in a row fault.
        spd_req = 11'd200;
        do_period(11'h410, 1'b1, 1'b0, 2);
        do_period(11'h420, 1'b1, 1'b0, 2);
        do_period(11'h430, 1'b1, 1'b0, 2);
        do_period(11'h440, 1'b1, 1'b0, 0);
        do_period(11'h450, 1'b1, 1'b0, 2);
        do_period(11'h460, 1'b1, 1'b0, 2);
        do_period(11'h470, 1'b1, 1'b0, 2);
        do_period(11'h480, 1'b1, 1'b0, 2);
        do_period(11'h400, 1'b0, 1'b1, 0);
        do_period(11'h400, 1'b0, 1'b1, 0);

        // Clear fault, re-enter RUN, then async reset mid-ramp.
        @(posedge clk); #1;
        fault_clr = 1'b1;
        exp_q.push_back({2'b00, 11'h400});
        @(posedge clk); #1;
        fault_clr = 1'b0;
        do_period(11'h400, 1'b1, 1'b0, 0);
        do_period(11'h410, 1'b1, 1'b0, 0);
        do_period(11'h420, 1'b1, 1'b0, 0);
        @(posedge clk); #1;
        PWM_synch = 1'b1;
        exp_q.push_back({2'b01, 11'h430});
        @(posedge clk); #1;
        PWM_synch = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("async_reset", {2'b00, 11'h400});
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
